// File: rtl/ext_port_arbiter.sv
// ext_port_arbiter
// Grants the shared 16-bit system bus to either the CPU or one of four
// expansion ports (A..D), and sequences each port transfer as
// SETUP -> STROBE -> HOLD with ready-based wait states and a timeout watchdog.
//
// Ports:
//   clk      system clock
//   r        synchronous active-high reset
//   cpu_req  CPU bus request (held for the whole tenure)
//   cpu_gnt  CPU owns the bus
//   ep_req   per-port transfer request (bit 0 = A .. bit 3 = D)
//   ep_dir   per-port direction, 1 = bus->port (we), 0 = port->bus (oe)
//   ep_rdy   per-port device ready, looked at only while that port strobes
//   ep_gnt   one-hot port grant, SETUP through HOLD
//   ep_we    port write enable strobes
//   ep_oe    port output enable strobes
//   ep_done  one-cycle completion pulse in HOLD
//   ep_err   one-cycle timeout pulse in HOLD
// All outputs are registered.
module ext_port_arbiter #(
  parameter int STROBE_MIN = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       r,
  input  logic       cpu_req,
  output logic       cpu_gnt,
  input  logic [3:0] ep_req,
  input  logic [3:0] ep_dir,
  input  logic [3:0] ep_rdy,
  output logic [3:0] ep_gnt,
  output logic [3:0] ep_we,
  output logic [3:0] ep_oe,
  output logic [3:0] ep_done,
  output logic [3:0] ep_err
);

  typedef enum logic [2:0] {IDLE, CPU, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] SMIN = 8'(STROBE_MIN);
  localparam logic [7:0] TMO  = 8'(TIMEOUT);

  state_t     state, state_d;
  logic [1:0] sel, sel_d;
  logic [1:0] rr_ptr, rr_ptr_d;
  logic       dir, dir_d;
  logic       ok, ok_d;
  logic       last_cpu, last_cpu_d;
  logic [7:0] cnt, cnt_d;

  logic [1:0] pick;
  logic       pick_vld;

  logic       cpu_gnt_d;
  logic [3:0] ep_gnt_d, ep_we_d, ep_oe_d, ep_done_d, ep_err_d;

  // Round-robin search starting at rr_ptr; walking the offsets from high to
  // low lets the closest requester overwrite any farther one.
  always_comb begin : rr_pick
    logic [1:0] idx;
    pick     = rr_ptr;
    pick_vld = |ep_req;
    idx      = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (ep_req[idx]) pick = idx;
    end
  end

  // Next-state and transfer bookkeeping
  always_comb begin
    state_d    = state;
    sel_d      = sel;
    dir_d      = dir;
    ok_d       = ok;
    last_cpu_d = last_cpu;
    rr_ptr_d   = rr_ptr;
    cnt_d      = 8'd0;
    case (state)
      IDLE: begin
        // On contention the side not served last wins.
        if (cpu_req && (!pick_vld || !last_cpu)) begin
          state_d = CPU;
        end else if (pick_vld) begin
          state_d    = SETUP;
          sel_d      = pick;
          dir_d      = ep_dir[pick];
          last_cpu_d = 1'b0;
          rr_ptr_d   = pick + 2'd1;
        end
      end
      CPU: begin
        if (!cpu_req) begin
          state_d    = IDLE;
          last_cpu_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 8'd1;
      end
      STROBE: begin
        if ((cnt >= SMIN) && ep_rdy[sel]) begin
          state_d = HOLD;
          ok_d    = 1'b1;
        end else if (cnt == TMO) begin
          state_d = HOLD;
          ok_d    = 1'b0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming state; registered below.
  always_comb begin
    logic [3:0] oh;
    oh        = 4'b0001 << sel_d;
    cpu_gnt_d = 1'b0;
    ep_gnt_d  = 4'b0000;
    ep_we_d   = 4'b0000;
    ep_oe_d   = 4'b0000;
    ep_done_d = 4'b0000;
    ep_err_d  = 4'b0000;
    case (state_d)
      CPU:   cpu_gnt_d = 1'b1;
      SETUP: ep_gnt_d  = oh;
      STROBE: begin
        ep_gnt_d = oh;
        ep_we_d  = dir_d ? oh : 4'b0000;
        ep_oe_d  = dir_d ? 4'b0000 : oh;
      end
      HOLD: begin
        ep_gnt_d  = oh;
        ep_done_d = ok_d ? oh : 4'b0000;
        ep_err_d  = ok_d ? 4'b0000 : oh;
      end
      default: ;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (r) begin
      state    <= IDLE;
      sel      <= 2'd0;
      rr_ptr   <= 2'd0;
      dir      <= 1'b0;
      ok       <= 1'b0;
      last_cpu <= 1'b0;
      cnt      <= 8'd0;
      cpu_gnt  <= 1'b0;
      ep_gnt   <= 4'b0000;
      ep_we    <= 4'b0000;
      ep_oe    <= 4'b0000;
      ep_done  <= 4'b0000;
      ep_err   <= 4'b0000;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      rr_ptr   <= rr_ptr_d;
      dir      <= dir_d;
      ok       <= ok_d;
      last_cpu <= last_cpu_d;
      cnt      <= cnt_d;
      cpu_gnt  <= cpu_gnt_d;
      ep_gnt   <= ep_gnt_d;
      ep_we    <= ep_we_d;
      ep_oe    <= ep_oe_d;
      ep_done  <= ep_done_d;
      ep_err   <= ep_err_d;
    end
  end

endmodule

// File: tb/tb_ext_port_arbiter.sv
// Testbench for ext_port_arbiter: two instances share stimulus,
// u0 with STROBE_MIN=1/TIMEOUT=255 and u1 with STROBE_MIN=2/TIMEOUT=8.
module tb_ext_port_arbiter;

  logic       clk = 1'b0;
  logic       r;
  logic       cpu_req;
  logic [3:0] ep_req, ep_dir, ep_rdy;

  logic       cpu_gnt0, cpu_gnt1;
  logic [3:0] gnt0, we0, oe0, done0, err0;
  logic [3:0] gnt1, we1, oe1, done1, err1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_port_arbiter #(.STROBE_MIN(1), .TIMEOUT(255)) u0 (
    .clk(clk), .r(r), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt0),
    .ep_req(ep_req), .ep_dir(ep_dir), .ep_rdy(ep_rdy),
    .ep_gnt(gnt0), .ep_we(we0), .ep_oe(oe0), .ep_done(done0), .ep_err(err0)
  );

  ext_port_arbiter #(.STROBE_MIN(2), .TIMEOUT(8)) u1 (
    .clk(clk), .r(r), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt1),
    .ep_req(ep_req), .ep_dir(ep_dir), .ep_rdy(ep_rdy),
    .ep_gnt(gnt1), .ep_we(we1), .ep_oe(oe1), .ep_done(done1), .ep_err(err1)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs0();
    return {11'd0, cpu_gnt0, gnt0, we0, oe0, done0, err0};
  endfunction

  function automatic logic [31:0] outs1();
    return {11'd0, cpu_gnt1, gnt1, we1, oe1, done1, err1};
  endfunction

  // Advance one clock and look at the outputs just after the edge;
  // the bus invariants are checked on every cycle for both instances.
  task automatic step();
    @(posedge clk);
    #1;
    check_vec("u0_excl",   32'(cpu_gnt0 && (|gnt0)), 32'd0);
    check_vec("u0_onehot", 32'($countones(gnt0) > 1), 32'd0);
    check_vec("u0_weoe",   32'(we0 & oe0), 32'd0);
    check_vec("u1_excl",   32'(cpu_gnt1 && (|gnt1)), 32'd0);
    check_vec("u1_onehot", 32'($countones(gnt1) > 1), 32'd0);
    check_vec("u1_weoe",   32'(we1 & oe1), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    r = 1'b1;
    step();
    r = 1'b0;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    r = 1'b1; cpu_req = 1'b0; ep_req = 4'b0; ep_dir = 4'b0; ep_rdy = 4'b0;
    idle(2);
    r = 1'b0;
    check_vec("init_outs0", outs0(), 32'd0);
    check_vec("init_outs1", outs1(), 32'd0);

    // Reset with a port A write strobe in progress
    ep_req = 4'b0001; ep_dir = 4'b0001; ep_rdy = 4'b0000;
    step();
    check_vec("rst_pre_gnt", 32'(gnt0), 32'h1);
    ep_req = 4'b0000;
    step();
    check_vec("rst_pre_we", 32'(we0), 32'h1);
    r = 1'b1;
    step();
    check_vec("rst_outs0_a", outs0(), 32'd0);
    check_vec("rst_outs1_a", outs1(), 32'd0);
    step();
    check_vec("rst_outs0_b", outs0(), 32'd0);
    r = 1'b0;
    idle(2);
    check_vec("rst_idle0", outs0(), 32'd0);
    check_vec("rst_idle1", outs1(), 32'd0);

    // Single write on port A, rdy tied high
    ep_req = 4'b0001; ep_dir = 4'b0001; ep_rdy = 4'b1111;
    step();
    check_vec("wr_c1_gnt", 32'(gnt0), 32'h1);
    check_vec("wr_c1_we",  32'(we0),  32'h0);
    ep_req = 4'b0000;
    step();
    check_vec("wr_c2_we",  32'(we0),  32'h1);
    check_vec("wr_c2_oe",  32'(oe0),  32'h0);
    check_vec("wr_c2_gnt", 32'(gnt0), 32'h1);
    step();
    check_vec("wr_c3_done", 32'(done0), 32'h1);
    check_vec("wr_c3_we",   32'(we0),   32'h0);
    check_vec("wr_c3_gnt",  32'(gnt0),  32'h1);
    step();
    check_vec("wr_c4_idle", outs0(), 32'd0);
    idle(3);

    // Port C read with wait states (u1: STROBE_MIN=2), ready in 5th strobe cycle
    ep_req = 4'b0100; ep_dir = 4'b0000; ep_rdy = 4'b0000;
    step();
    check_vec("ws_gnt", 32'(gnt1), 32'h4);
    check_vec("ws_setup_oe", 32'(oe1), 32'h0);
    ep_req = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_vec($sformatf("ws_oe_%0d", k), 32'(oe1), 32'h4);
      check_vec($sformatf("ws_we_%0d", k), 32'(we1), 32'h0);
      if (k == 5) ep_rdy = 4'b0100;
    end
    step();
    check_vec("ws_done", 32'(done1), 32'h4);
    check_vec("ws_hold_oe", 32'(oe1), 32'h0);
    check_vec("ws_hold_gnt", 32'(gnt1), 32'h4);
    step();
    check_vec("ws_idle", outs1(), 32'd0);
    ep_rdy = 4'b0000;
    idle(3);

    // Port B write that never becomes ready (u1: TIMEOUT=8)
    ep_req = 4'b0010; ep_dir = 4'b0010; ep_rdy = 4'b0000;
    step();
    check_vec("to_gnt", 32'(gnt1), 32'h2);
    ep_req = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_vec($sformatf("to_we_%0d", k), 32'(we1), 32'h2);
    end
    step();
    check_vec("to_err",  32'(err1),  32'h2);
    check_vec("to_done", 32'(done1), 32'h0);
    check_vec("to_we_off", 32'(we1 | oe1), 32'h0);
    step();
    check_vec("to_idle", outs1(), 32'd0);
    ep_rdy = 4'b1111;
    idle(4);

    // Round-robin with all four ports requesting
    do_reset();
    ep_req = 4'b1111; ep_dir = 4'b1111; ep_rdy = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      check_vec($sformatf("rr_gnt_%0d", t), 32'(gnt0), 32'(rr_exp[t]));
      idle(2);
      step();
      check_vec($sformatf("rr_gap_%0d", t), 32'(gnt0), 32'h0);
    end
    ep_req = 4'b0000;
    idle(4);

    // CPU / port fairness
    do_reset();
    cpu_req = 1'b1; ep_req = 4'b0001; ep_dir = 4'b0001; ep_rdy = 4'b1111;
    step();
    check_vec("fr_cpu_first", 32'(cpu_gnt0), 32'h1);
    check_vec("fr_port_wait", 32'(gnt0), 32'h0);
    step();
    check_vec("fr_cpu_hold", 32'(cpu_gnt0), 32'h1);
    cpu_req = 1'b0;
    step();
    check_vec("fr_cpu_rel", 32'(cpu_gnt0), 32'h0);
    cpu_req = 1'b1;
    step();
    check_vec("fr_port_gnt", 32'(gnt0), 32'h1);
    check_vec("fr_cpu_wait", 32'(cpu_gnt0), 32'h0);
    ep_req = 4'b0000;
    step();
    check_vec("fr_port_we", 32'(we0), 32'h1);
    step();
    check_vec("fr_port_done", 32'(done0), 32'h1);
    check_vec("fr_cpu_hold_off", 32'(cpu_gnt0), 32'h0);
    step();
    check_vec("fr_turnaround", outs0(), 32'd0);
    step();
    check_vec("fr_cpu_again", 32'(cpu_gnt0), 32'h1);
    cpu_req = 1'b0;
    step();
    check_vec("fr_cpu_end", outs0(), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
